// File: rtl/kernel_line_buffer.sv
// KH-row sliding-window line buffer: stores full rows in a ring and presents
// a KH-row window (oldest row first) every STRIDE rows within a frame.
module kernel_line_buffer #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned W         = 24,
   parameter int unsigned K         = 6,
   parameter int unsigned H         = 24,
   parameter int unsigned KH        = 3,
   parameter int unsigned STRIDE    = 1,
   parameter int unsigned ROW_BITS  = W * DATA_BITS * K
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [ROW_BITS-1:0]      row_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [KH*ROW_BITS-1:0]   window_o,
   output logic [((H > 1) ? $clog2(H) : 1)-1:0] row_idx_o,
   output logic                     last_o
);

   localparam int unsigned IDX_W = (H > 1) ? $clog2(H) : 1;
   localparam int unsigned WP_W  = (KH > 1) ? $clog2(KH) : 1;
   localparam int unsigned PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   if (KH < 2 || KH > H || STRIDE < 1) begin : g_param_check
      $error("kernel_line_buffer: illegal KH/STRIDE parameters");
   end

   logic [ROW_BITS-1:0] ring_q [KH];
   logic [ROW_BITS-1:0] ring_d [KH];
   logic [WP_W-1:0]     wp_q, wp_d;
   logic [IDX_W-1:0]    rc_q, rc_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [IDX_W-1:0]    row_idx_q, row_idx_d;

   logic accept;
   logic full_enough;
   logic emit;

   // A new row may only displace the oldest one while the pending window leaves.
   assign ready_o     = ~clear_i & (~valid_q | ready_i);
   assign accept      = valid_i & ready_o;
   assign full_enough = (32'(rc_q) + 32'd1) >= KH;
   assign emit        = accept & full_enough & (ph_q == '0);

   always_comb begin
      ring_d    = ring_q;
      wp_d      = wp_q;
      rc_d      = rc_q;
      ph_d      = ph_q;
      valid_d   = valid_q;
      last_d    = last_q;
      row_idx_d = row_idx_q;
      if (clear_i) begin
         wp_d      = '0;
         rc_d      = '0;
         ph_d      = '0;
         valid_d   = 1'b0;
         last_d    = 1'b0;
         row_idx_d = '0;
      end else begin
         if (valid_q && ready_i) begin
            valid_d = 1'b0;
         end
         if (accept) begin
            ring_d[wp_q] = row_i;
            wp_d = (32'(wp_q) == KH - 1) ? '0 : WP_W'(32'(wp_q) + 32'd1);
            // Phase only runs once the first window of the frame is reachable.
            if (full_enough) begin
               ph_d = (32'(ph_q) == STRIDE - 1) ? '0 : PH_W'(32'(ph_q) + 32'd1);
            end
            if (32'(rc_q) == H - 1) begin
               rc_d = '0;
               ph_d = '0;
            end else begin
               rc_d = IDX_W'(32'(rc_q) + 32'd1);
            end
            if (emit) begin
               valid_d   = 1'b1;
               row_idx_d = IDX_W'(32'(rc_q) + 32'd1 - KH);
               last_d    = (32'(rc_q) + 32'd1 + STRIDE) > H;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(KH); i++) begin
            ring_q[i] <= '0;
         end
         wp_q      <= '0;
         rc_q      <= '0;
         ph_q      <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         row_idx_q <= '0;
      end else begin
         ring_q    <= ring_d;
         wp_q      <= wp_d;
         rc_q      <= rc_d;
         ph_q      <= ph_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         row_idx_q <= row_idx_d;
      end
   end

   // Oldest row sits at the write pointer; rotate the ring onto the window slots.
   always_comb begin
      window_o = '0;
      for (int unsigned j = 0; j < KH; j++) begin
         int unsigned idx;
         idx = 32'(wp_q) + j;
         if (idx >= KH) begin
            idx = idx - KH;
         end
         window_o[j*ROW_BITS +: ROW_BITS] = ring_q[WP_W'(idx)];
      end
   end

   assign valid_o   = valid_q;
   assign last_o    = last_q;
   assign row_idx_o = row_idx_q;

endmodule

// File: doc/kernel_line_buffer.md
Name: kernel_line_buffer

Overview:
- Parametrised KH-row sliding-window line buffer for the conv datapath. Sits between the feature-map row source and the KHxKH convolution engine.
- Accepts one full row (W pixels x K channels) per handshake and stores rows in a ring. Presents a KH-row window, oldest row first, every STRIDE rows once KH rows of the current frame are held.
- Successor to the fixed 3-row buffer. Adds: configurable depth, vertical stride, valid/ready backpressure on both sides, frame tracking (top-row index, last-window flag) and synchronous clear.

Parameters:
- DATA_BITS, 8, bits per pixel per channel
- W, 24, pixels per row
- K, 6, channels per pixel
- H, 24, rows per frame
- KH, 3, window height (rows stored); legal range 2 <= KH <= H
- STRIDE, 1, vertical stride between emitted windows; legal range 1 <= STRIDE <= H
- ROW_BITS, W*DATA_BITS*K, derived row width; not to be overridden

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous frame abort
- valid_i  input  1  input row valid
- ready_o  output  1  input row accepted when valid_i & ready_o
- row_i  input  ROW_BITS  input row data
- valid_o  output  1  window valid
- ready_i  input  1  window consumed when valid_o & ready_i
- window_o  output  KH*ROW_BITS  slot j (bits [(j+1)*ROW_BITS-1 : j*ROW_BITS]) = j-th oldest stored row; slot 0 = top row
- row_idx_o  output  max(1,$clog2(H))  frame row index of window slot 0
- last_o  output  1  current window is the final window of the frame

Behaviour:
- Reset (resetn low, asynchronous): all row storage is 0.
  - Write pointer is 0; row count is 0; stride phase is 0.
  - Outputs: valid_o 0, last_o 0, row_idx_o 0, window_o all zeros.
  - Reset mid-frame discards the frame; the next accepted row is row 0.
- Storage and write pointer:
  - Ring of KH row registers with write pointer wp, 0..KH-1, wrapping KH-1 -> 0.
  - On accept: row_i is written to slot wp and wp advances.
  - window_o slot j = ring[(wp+j) mod KH]. It is driven from storage, so it is stable while the ring is not written.
- ready_o = !clear_i & (!valid_o | ready_i).
  - A new row may overwrite the oldest row only in the same cycle the pending window is consumed.
- Row count rc (0..H-1) counts rows accepted in the current frame.
  - On accepting row rc: if rc == H-1, rc wraps to 0 (next frame starts automatically); otherwise rc increments.
- Emission rule: let n be the number of rows accepted this frame including the current one (1..H). A window is emitted iff n >= KH and (n-KH) mod STRIDE == 0.
  - Implement with a phase counter, not a divider.
- Output timing:
  - valid_o rises in the cycle after the accepting edge (latency 1 cycle from input handshake).
  - valid_o, window_o, row_idx_o and last_o hold until ready_i is high.
  - valid_o clears after the consuming edge unless a new emitting row is accepted on the same edge, in which case it stays 1 with the new window.
- row_idx_o = n-KH, registered with valid_o.
- last_o = (n + STRIDE > H), registered with valid_o.
  - Rows after the last window (n < H) are accepted and only advance rc.
- Throughput: one row per cycle sustained when ready_i is held high, including with STRIDE=1.
- clear_i (synchronous, highest priority after reset):
  - rc, wp and phase are zeroed; valid_o and last_o are cleared.
  - Any input that cycle is dropped (ready_o is 0).
  - Storage contents need not be cleared.
- Cross-frame boundary: windows never span frames. After a wrap, the first window of the new frame requires KH new rows.
- Behaviour with illegal parameters is undefined. Elaboration must fail on KH < 2, KH > H or STRIDE < 1.

Test Plan:
- KH=3, H=6, STRIDE=1, rows filled with constant r+1 (r = 0..5), ready_i=1, back-to-back.
  - Required: exactly 4 windows, 1 cycle after rows 2, 3, 4, 5.
  - Slot data {1,2,3}, {2,3,4}, {3,4,5}, {4,5,6}; row_idx_o 0, 1, 2, 3; last_o only on the 4th window; ready_o constantly 1.
- KH=3, H=7, STRIDE=2.
  - Required: windows with row_idx_o 0, 2, 4; last_o on the 3rd window.
  - Then with H=6, STRIDE=2: windows at row_idx_o 0 and 2; last_o on idx 2; row 5 accepted with no window.
- Backpressure: ready_i=0 for 5 cycles while valid_o=1 and valid_i=1.
  - Required: ready_o=0; window_o, row_idx_o and valid_o stable for all 5 cycles; no row lost.
  - When ready_i goes 1: the pending row is accepted that cycle and the next window appears one cycle later.
- Two frames streamed back to back (KH=3, H=6).
  - Required: the 2nd frame's first window appears only after its 3rd row, with row_idx_o=0 and slot data from the 2nd frame only.
- Disruption cases:
  - clear_i pulsed after 4 rows with valid_o=1: valid_o goes 0 next cycle and the following rows restart at row_idx 0.
  - resetn asserted mid-frame: all outputs return to 0 immediately, without waiting for a clock edge.
